// File: rtl/rec_tran_arq.sv
// Serial OTN frame receiver: line synchroniser, bit-offset pattern hunt, byte
// deserialiser feeding a first-word-fall-through FIFO, and ARQ ACK/NACK generation.
module rec_tran_arq #(
    parameter int                    SYNC_STAGES  = 2,
    parameter int                    SYNC_BITS    = 48,
    parameter logic [SYNC_BITS-1:0]  SYNC_PATTERN = 48'hF6F6F6282828,
    parameter int                    FRAME_BYTES  = 4080,
    parameter int                    FIFO_DEPTH   = 16,
    parameter int                    ACK_CYCLES   = 8,
    parameter int                    CRC_TIMEOUT  = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_otn_rx_data,
    input  logic                          i_arq_en,
    input  logic                          i_crc_err,
    input  logic                          i_crc_err_valid,
    output logic [7:0]                    o_frame_data,
    output logic                          o_frame_last,
    output logic                          o_frame_data_valid,
    input  logic                          i_frame_data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_otn_rx_ack,
    output logic                          o_otn_rx_nack,
    output logic                          o_locked,
    output logic                          o_overflow
);

    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TO_W  = $clog2(CRC_TIMEOUT + 1);
    localparam int AK_W  = $clog2(ACK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CRC_TIMEOUT - 1);
    localparam logic [AK_W-1:0]  AK_LAST  = AK_W'(ACK_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HUNT     = 3'd0,
        ST_RECV     = 3'd1,
        ST_CRC_WAIT = 3'd2,
        ST_ACK      = 3'd3,
        ST_NACK     = 3'd4
    } state_t;

    state_t                 state_r, state_n;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_BITS-1:0]   win_r;
    logic [2:0]             bit_cnt_r, bit_cnt_n;
    logic [CNT_W-1:0]       byte_cnt_r, byte_cnt_n;
    logic [6:0]             shift_r, shift_n;
    logic                   frame_ovf_r, frame_ovf_n;
    logic [TO_W-1:0]        to_cnt_r, to_cnt_n;
    logic [AK_W-1:0]        ack_cnt_r, ack_cnt_n;
    logic [8:0]             mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]       level_r, level_n;
    logic                   valid_r, ack_r, nack_r, locked_r, ovf_r;
    logic                   byte_done_s, last_byte_s, ovf_seen_s;
    logic                   pop_s, full_s, drop_s, wr_en_s;
    logic [8:0]             push_word_s, head_s;

    // The window holds the newest synchronised bit at the LSB; RECV consumes win_r[0]
    assign byte_done_s = (state_r == ST_RECV) && (bit_cnt_r == 3'd7);
    assign last_byte_s = byte_done_s && (byte_cnt_r == LAST_IDX);
    assign push_word_s = {last_byte_s, shift_r, win_r[0]};
    assign ovf_seen_s  = frame_ovf_r | drop_s;
    assign head_s      = mem_r[rd_ptr_r];

    // Line synchroniser and pattern window; the window shifts in every state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= '0;
            win_r  <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_otn_rx_data};
            win_r  <= {win_r[SYNC_BITS-2:0], sync_r[SYNC_STAGES-1]};
        end
    end

    // FIFO push/pop arbitration; a full FIFO only accepts a push alongside a pop
    always_comb begin
        level_n = level_r;
        pop_s   = valid_r & i_frame_data_ready;
        full_s  = (level_r == FULL_LVL);
        drop_s  = byte_done_s & full_s & ~pop_s;
        wr_en_s = byte_done_s & ~drop_s;
        case ({wr_en_s, pop_s})
            2'b10:   level_n = level_r + LVL_W'(1);
            2'b01:   level_n = level_r - LVL_W'(1);
            default: level_n = level_r;
        endcase
    end

    // Frame FSM next state; counters are zeroed on every entry to the state using them
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        byte_cnt_n  = byte_cnt_r;
        shift_n     = shift_r;
        frame_ovf_n = frame_ovf_r;
        to_cnt_n    = to_cnt_r;
        ack_cnt_n   = ack_cnt_r;
        case (state_r)
            ST_HUNT: begin
                to_cnt_n  = '0;
                ack_cnt_n = '0;
                if (win_r == SYNC_PATTERN) begin
                    state_n     = ST_RECV;
                    bit_cnt_n   = 3'd0;
                    byte_cnt_n  = '0;
                    frame_ovf_n = 1'b0;
                end else begin
                    state_n = ST_HUNT;
                end
            end
            ST_RECV: begin
                to_cnt_n    = '0;
                ack_cnt_n   = '0;
                shift_n     = {shift_r[5:0], win_r[0]};
                bit_cnt_n   = bit_cnt_r + 3'd1;
                frame_ovf_n = ovf_seen_s;
                if (byte_done_s) begin
                    byte_cnt_n = byte_cnt_r + CNT_W'(1);
                end else begin
                    byte_cnt_n = byte_cnt_r;
                end
                if (!last_byte_s) begin
                    state_n = ST_RECV;
                end else if (!i_arq_en) begin
                    state_n = ST_HUNT;
                end else if (ovf_seen_s) begin
                    state_n = ST_NACK;
                end else begin
                    state_n = ST_CRC_WAIT;
                end
            end
            ST_CRC_WAIT: begin
                ack_cnt_n = '0;
                if (i_crc_err_valid) begin
                    state_n = i_crc_err ? ST_NACK : ST_ACK;
                end else if (to_cnt_r == TO_LAST) begin
                    state_n = ST_NACK;
                end else begin
                    to_cnt_n = to_cnt_r + TO_W'(1);
                end
            end
            ST_ACK, ST_NACK: begin
                if (ack_cnt_r == AK_LAST) begin
                    state_n = ST_HUNT;
                end else begin
                    ack_cnt_n = ack_cnt_r + AK_W'(1);
                end
            end
            default: begin
                state_n = ST_HUNT;
            end
        endcase
    end

    // FSM state, counters and registered status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_HUNT;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= '0;
            shift_r     <= 7'd0;
            frame_ovf_r <= 1'b0;
            to_cnt_r    <= '0;
            ack_cnt_r   <= '0;
            locked_r    <= 1'b0;
            ack_r       <= 1'b0;
            nack_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            byte_cnt_r  <= byte_cnt_n;
            shift_r     <= shift_n;
            frame_ovf_r <= frame_ovf_n;
            to_cnt_r    <= to_cnt_n;
            ack_cnt_r   <= ack_cnt_n;
            locked_r    <= (state_n == ST_RECV);
            ack_r       <= (state_n == ST_ACK);
            nack_r      <= (state_n == ST_NACK);
            ovf_r       <= drop_s;
        end
    end

    // FIFO storage and pointers; storage is cleared so the head reads 0 out of reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 9'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_n;
            valid_r <= (level_n != '0);
        end
    end

    assign o_frame_data       = head_s[7:0];
    assign o_frame_last       = head_s[8];
    assign o_frame_data_valid = valid_r;
    assign o_fifo_level       = level_r;
    assign o_otn_rx_ack       = ack_r;
    assign o_otn_rx_nack      = nack_r;
    assign o_locked           = locked_r;
    assign o_overflow         = ovf_r;

endmodule

// File: tb/tb_rec_tran_arq.sv
// Directed bench for rec_tran_arq: a 4-byte-frame instance for most scenarios and an
// 8-byte-frame instance for FIFO overflow.
module tb_rec_tran_arq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx, arq, crc_err, crc_valid, ready;
    logic [7:0] data;
    logic       last, valid, ack, nack, locked, ovf;
    logic [2:0] level;
    logic       rx8, arq8, crc_err8, crc_valid8, ready8;
    logic [7:0] data8;
    logic       last8, valid8, ack8, nack8, locked8, ovf8;
    logic [2:0] level8;

    int total = 0;
    int bad   = 0;

    rec_tran_arq #(
        .SYNC_STAGES(2), .SYNC_BITS(16), .SYNC_PATTERN(16'hF628), .FRAME_BYTES(4),
        .FIFO_DEPTH(4), .ACK_CYCLES(4), .CRC_TIMEOUT(20)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_otn_rx_data(rx), .i_arq_en(arq),
        .i_crc_err(crc_err), .i_crc_err_valid(crc_valid),
        .o_frame_data(data), .o_frame_last(last), .o_frame_data_valid(valid),
        .i_frame_data_ready(ready), .o_fifo_level(level),
        .o_otn_rx_ack(ack), .o_otn_rx_nack(nack), .o_locked(locked), .o_overflow(ovf)
    );

    rec_tran_arq #(
        .SYNC_STAGES(2), .SYNC_BITS(16), .SYNC_PATTERN(16'hF628), .FRAME_BYTES(8),
        .FIFO_DEPTH(4), .ACK_CYCLES(4), .CRC_TIMEOUT(20)
    ) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_otn_rx_data(rx8), .i_arq_en(arq8),
        .i_crc_err(crc_err8), .i_crc_err_valid(crc_valid8),
        .o_frame_data(data8), .o_frame_last(last8), .o_frame_data_valid(valid8),
        .i_frame_data_ready(ready8), .o_fifo_level(level8),
        .o_otn_rx_ack(ack8), .o_otn_rx_nack(nack8), .o_locked(locked8), .o_overflow(ovf8)
    );

    // Output monitor: records accepted bytes and counts high cycles of status outputs
    logic [8:0] cap [0:63];
    int cap_n = 0, ack_cnt = 0, nack_cnt = 0, both_cnt = 0, locked_cnt = 0;
    int ovf8_cnt = 0, nack8_cnt = 0, ack8_cnt = 0;
    always @(negedge clk) begin
        if (valid && ready && cap_n < 64) begin
            cap[cap_n] <= {last, data};
            cap_n      <= cap_n + 1;
        end
        if (ack)          ack_cnt    <= ack_cnt + 1;
        if (nack)         nack_cnt   <= nack_cnt + 1;
        if (ack && nack)  both_cnt   <= both_cnt + 1;
        if (locked)       locked_cnt <= locked_cnt + 1;
        if (ovf8)         ovf8_cnt   <= ovf8_cnt + 1;
        if (nack8)        nack8_cnt  <= nack8_cnt + 1;
        if (ack8)         ack8_cnt   <= ack8_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic step(input logic b, input logic sel);
        @(posedge clk);
        #1;
        if (sel) rx8 = b;
        else     rx  = b;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sel);
        for (int i = 7; i >= 0; i--) step(b[i], sel);
    endtask

    task automatic send_frame4(input logic [31:0] p);
        send_byte(8'hF6, 1'b0);
        send_byte(8'h28, 1'b0);
        for (int k = 3; k >= 0; k--) send_byte(p[k*8 +: 8], 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx  = 1'b0;
            rx8 = 1'b0;
        end
    endtask

    task automatic wait_unlock(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!locked) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx = 1'b0; arq = 1'b0; crc_err = 1'b0; crc_valid = 1'b0; ready = 1'b1;
        rx8 = 1'b0; arq8 = 1'b1; crc_err8 = 1'b0; crc_valid8 = 1'b0; ready8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({valid, last, ack, nack, locked, ovf} !== 6'd0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000", {valid, last, ack, nack, locked, ovf});
        end
        total++;
        if (level !== 3'd0 || data !== 8'd0) begin
            bad++; $display("FAIL reset_fifo level=%0d data=%h exp 0/00", level, data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned;
        int base, a0, n0;
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        base = cap_n; a0 = ack_cnt; n0 = nack_cnt;
        arq = 1'b0;
        send_frame4(32'h11223344);
        idle(12);
        total++;
        if (cap_n - base !== 4) begin
            bad++; $display("FAIL aligned_count got=%0d exp=4", cap_n - base);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[base+k] !== {(k == 3), exp_b[k]}) begin
                bad++; $display("FAIL aligned_byte%0d got=%h exp=%h", k, cap[base+k], {(k == 3), exp_b[k]});
            end
        end
        total++;
        if (locked !== 1'b0 || ack_cnt - a0 !== 0 || nack_cnt - n0 !== 0) begin
            bad++; $display("FAIL aligned_hunt locked=%b ack=%0d nack=%0d exp 0/0/0", locked, ack_cnt - a0, nack_cnt - n0);
        end
    endtask

    task automatic test_misaligned;
        int base, lc;
        logic [7:0] exp_b [4];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        base = cap_n;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        send_frame4(32'hAABBCCDD);
        idle(12);
        total++;
        if (cap_n - base !== 4) begin
            bad++; $display("FAIL misaligned_count got=%0d exp=4", cap_n - base);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[base+k] !== {(k == 3), exp_b[k]}) begin
                bad++; $display("FAIL misaligned_byte%0d got=%h exp=%h", k, cap[base+k], {(k == 3), exp_b[k]});
            end
        end
        lc = locked_cnt;
        idle(20);
        send_byte(8'hF6, 1'b0); send_byte(8'h29, 1'b0);
        idle(20);
        send_byte(8'h76, 1'b0); send_byte(8'h28, 1'b0);
        idle(20);
        total++;
        if (locked_cnt - lc !== 0) begin
            bad++; $display("FAIL near_miss_lock got=%0d locked cycles exp=0", locked_cnt - lc);
        end
    endtask

    task automatic test_arq_good_bad;
        int a0, n0, b0;
        logic ok;
        for (int pass = 0; pass < 2; pass++) begin
            a0 = ack_cnt; n0 = nack_cnt; b0 = both_cnt;
            arq = 1'b1;
            send_frame4(32'h01020304);
            wait_unlock(ok);
            total++;
            if (ok !== 1'b1) begin
                bad++; $display("FAIL arq%0d_unlock got=%b exp=1", pass, ok);
            end
            repeat (3) @(posedge clk);
            #1;
            crc_err = (pass == 1); crc_valid = 1'b1;
            @(posedge clk);
            #1;
            crc_valid = 1'b0; crc_err = 1'b0;
            idle(12);
            total++;
            if (ack_cnt - a0 !== (pass == 0 ? 4 : 0) || nack_cnt - n0 !== (pass == 1 ? 4 : 0)) begin
                bad++; $display("FAIL arq%0d_resp ack=%0d nack=%0d exp=%0d/%0d", pass,
                                ack_cnt - a0, nack_cnt - n0, (pass == 0 ? 4 : 0), (pass == 1 ? 4 : 0));
            end
            total++;
            if (both_cnt - b0 !== 0 || locked !== 1'b0) begin
                bad++; $display("FAIL arq%0d_exclusive both=%0d locked=%b exp 0/0", pass, both_cnt - b0, locked);
            end
        end
    endtask

    task automatic test_crc_timeout;
        int a0, n0, cnt;
        logic ok, found;
        a0 = ack_cnt; n0 = nack_cnt;
        arq = 1'b1;
        send_frame4(32'h5A5A5A5A);
        wait_unlock(ok);
        cnt = 0; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (nack) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (ok !== 1'b1 || found !== 1'b1 || cnt !== 20) begin
            bad++; $display("FAIL timeout_latency ok=%b found=%b cycles=%0d exp 1/1/20", ok, found, cnt);
        end
        idle(10);
        total++;
        if (nack_cnt - n0 !== 4 || ack_cnt - a0 !== 0) begin
            bad++; $display("FAIL timeout_nack nack=%0d ack=%0d exp 4/0", nack_cnt - n0, ack_cnt - a0);
        end
        a0 = ack_cnt; n0 = nack_cnt;
        send_frame4(32'h5A5A5A5A);
        wait_unlock(ok);
        repeat (19) @(posedge clk);
        #1;
        crc_err = 1'b0; crc_valid = 1'b1;
        @(posedge clk);
        #1;
        crc_valid = 1'b0;
        idle(10);
        total++;
        if (ok !== 1'b1 || ack_cnt - a0 !== 4 || nack_cnt - n0 !== 0) begin
            bad++; $display("FAIL timeout_verdict_wins ok=%b ack=%0d nack=%0d exp 1/4/0", ok, ack_cnt - a0, nack_cnt - n0);
        end
    endtask

    task automatic test_overflow;
        int o8, n8, a8;
        logic seen_lock, unlocked, nack_at_end;
        o8 = ovf8_cnt; n8 = nack8_cnt; a8 = ack8_cnt;
        ready8 = 1'b0;
        send_byte(8'hF6, 1'b1); send_byte(8'h28, 1'b1);
        for (int k = 0; k < 8; k++) send_byte(8'h10 + 8'(k), 1'b1);
        seen_lock = locked8; unlocked = 1'b0; nack_at_end = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!locked8) begin
                unlocked = 1'b1;
                nack_at_end = nack8;
                break;
            end
        end
        total++;
        if (seen_lock !== 1'b1 || unlocked !== 1'b1 || nack_at_end !== 1'b1) begin
            bad++; $display("FAIL ovf_direct_nack locked=%b unlocked=%b nack=%b exp 1/1/1", seen_lock, unlocked, nack_at_end);
        end
        idle(8);
        total++;
        if (level8 !== 3'd4 || valid8 !== 1'b1) begin
            bad++; $display("FAIL ovf_level got=%0d valid=%b exp=4/1", level8, valid8);
        end
        total++;
        if (ovf8_cnt - o8 !== 4 || nack8_cnt - n8 !== 4 || ack8_cnt - a8 !== 0) begin
            bad++; $display("FAIL ovf_counts ovf=%0d nack=%0d ack=%0d exp 4/4/0", ovf8_cnt - o8, nack8_cnt - n8, ack8_cnt - a8);
        end
        @(posedge clk);
        #1;
        ready8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (valid8 !== 1'b1 || data8 !== 8'h10 + 8'(k) || last8 !== 1'b0) begin
                bad++; $display("FAIL ovf_drain%0d valid=%b data=%h last=%b exp 1/%h/0", k, valid8, data8, last8, 8'h10 + 8'(k));
            end
        end
        @(negedge clk);
        total++;
        if (valid8 !== 1'b0 || level8 !== 3'd0) begin
            bad++; $display("FAIL ovf_empty valid=%b level=%0d exp 0/0", valid8, level8);
        end
    endtask

    task automatic test_async_reset;
        int base, a0, n0;
        logic [7:0] exp_b [4];
        exp_b = '{8'h55, 8'h66, 8'h77, 8'h88};
        a0 = ack_cnt; n0 = nack_cnt;
        arq = 1'b1; ready = 1'b0;
        send_byte(8'hF6, 1'b0); send_byte(8'h28, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        idle(5);
        total++;
        if (level !== 3'd2 || locked !== 1'b1 || data !== 8'h11) begin
            bad++; $display("FAIL rst_pre level=%0d locked=%b data=%h exp 2/1/11", level, locked, data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({valid, last, ack, nack, locked, ovf} !== 6'd0 || level !== 3'd0 || data !== 8'd0) begin
            bad++; $display("FAIL rst_async flags=%b level=%0d data=%h exp 0", {valid, last, ack, nack, locked, ovf}, level, data);
        end
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1; arq = 1'b0;
        idle(30);
        total++;
        if (ack_cnt - a0 !== 0 || nack_cnt - n0 !== 0) begin
            bad++; $display("FAIL rst_no_resp ack=%0d nack=%0d exp 0/0", ack_cnt - a0, nack_cnt - n0);
        end
        base = cap_n;
        send_frame4(32'h55667788);
        idle(12);
        total++;
        if (cap_n - base !== 4) begin
            bad++; $display("FAIL rst_after_count got=%0d exp=4", cap_n - base);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[base+k] !== {(k == 3), exp_b[k]}) begin
                bad++; $display("FAIL rst_after_byte%0d got=%h exp=%h", k, cap[base+k], {(k == 3), exp_b[k]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_arq_good_bad();
        test_crc_timeout();
        test_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
